event_unit_barrier_arbiter: RTL and testbench

- Shares one hardware-barrier slave port between NB_CORES per-core demux request ports.
- Used inside the event unit in place of the fixed-priority find-first-one barrier selection.
- Provides fair round-robin arbitration, locks the selected requester until it is granted, and routes the single outstanding response back to the core that issued it.
- Flat vector ports; bus-interface adaptation is done by the instantiating module.

---
 rtl/event_unit_barrier_arbiter.sv | 144 ++++++++++++++
 tb/tb_event_unit_barrier_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/event_unit_barrier_arbiter.sv
// Round-robin arbiter sharing one hardware-barrier slave port between
// NB_CORES per-core request ports. Holds the selected requester until it is
// granted and routes the single outstanding response back to its issuer.
// Build option: EVENT_UNIT_BARR_ARB_RR_EN selects round-robin arbitration;
// when undefined the pointer stays at 0 (fixed priority, lowest index wins).
module event_unit_barrier_arbiter #(
  parameter int unsigned NB_CORES     = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LOG_NB_CORES = $clog2(NB_CORES)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_CORES-1:0]            core_req_i,
  input  logic [NB_CORES*ADDR_WIDTH-1:0] core_add_i,
  input  logic [NB_CORES-1:0]            core_wen_i,
  input  logic [NB_CORES*32-1:0]         core_wdata_i,
  output logic [NB_CORES-1:0]            core_gnt_o,
  output logic [NB_CORES-1:0]            core_r_valid_o,
  output logic [31:0]                    core_r_rdata_o,
  output logic                           barr_req_o,
  output logic [ADDR_WIDTH-1:0]          barr_add_o,
  output logic                           barr_wen_o,
  output logic [31:0]                    barr_wdata_o,
  input  logic                           barr_gnt_i,
  input  logic                           barr_r_valid_i,
  input  logic [31:0]                    barr_r_rdata_i,
  output logic                           prot_err_o
);

  logic [LOG_NB_CORES-1:0] rr_ptr_q, rr_ptr_d;
  logic                    lock_vld_q, lock_vld_d;
  logic [LOG_NB_CORES-1:0] lock_idx_q, lock_idx_d;
  logic                    resp_pend_q, resp_pend_d;
  logic [LOG_NB_CORES-1:0] resp_idx_q, resp_idx_d;
  logic                    prot_err_q, prot_err_d;

  logic [LOG_NB_CORES-1:0] sel_rr;
  logic [LOG_NB_CORES-1:0] sel;
  logic [LOG_NB_CORES-1:0] scan_idx;
  logic                    found;
  logic                    issue_ok;
  logic                    lock_drop;
  logic                    handshake;

  // Round-robin scan: first requesting core at or above rr_ptr, wrapping
  always_comb begin
    sel_rr   = '0;
    scan_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NB_CORES; i++) begin
      scan_idx = LOG_NB_CORES'((32'(rr_ptr_q) + i) % NB_CORES);
      if (!found && core_req_i[scan_idx]) begin
        found  = 1'b1;
        sel_rr = scan_idx;
      end
    end
  end

  // Request forwarding; a locked core that withdrew suppresses issue for one
  // cycle so the grant never lands on a core that is no longer requesting
  always_comb begin
    sel        = lock_vld_q ? lock_idx_q : sel_rr;
    lock_drop  = lock_vld_q & ~core_req_i[lock_idx_q];
    issue_ok   = ~resp_pend_q | barr_r_valid_i;
    barr_req_o = (|core_req_i) & issue_ok & ~lock_drop;
    handshake  = barr_req_o & barr_gnt_i;
    if (barr_req_o) begin
      barr_add_o   = core_add_i[32'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
      barr_wen_o   = core_wen_i[sel];
      barr_wdata_o = core_wdata_i[32'(sel)*32 +: 32];
    end else begin
      barr_add_o   = '0;
      barr_wen_o   = 1'b0;
      barr_wdata_o = '0;
    end
  end

  // Grant and response demultiplexing back to the cores
  always_comb begin
    core_gnt_o     = '0;
    core_r_valid_o = '0;
    core_r_rdata_o = '0;
    if (handshake) begin
      core_gnt_o[sel] = 1'b1;
    end
    if (resp_pend_q && barr_r_valid_i) begin
      core_r_valid_o[resp_idx_q] = 1'b1;
      core_r_rdata_o             = barr_r_rdata_i;
    end
  end

  // Next-state: a handshake in the response cycle keeps resp_pend set
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    lock_vld_d  = lock_vld_q;
    lock_idx_d  = lock_idx_q;
    resp_pend_d = resp_pend_q;
    resp_idx_d  = resp_idx_q;
    prot_err_d  = prot_err_q;
    if (barr_r_valid_i) begin
      if (resp_pend_q) begin
        resp_pend_d = 1'b0;
      end else begin
        prot_err_d = 1'b1;
      end
    end
    if (handshake) begin
`ifdef EVENT_UNIT_BARR_ARB_RR_EN
      rr_ptr_d = (sel == LOG_NB_CORES'(NB_CORES-1)) ? '0 : sel + 1'b1;
`endif
      lock_vld_d  = 1'b0;
      resp_pend_d = 1'b1;
      resp_idx_d  = sel;
    end else if (barr_req_o) begin
      lock_vld_d = 1'b1;
      lock_idx_d = sel;
    end else if (lock_drop) begin
      lock_vld_d = 1'b0;
      prot_err_d = 1'b1;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q    <= '0;
      lock_vld_q  <= 1'b0;
      lock_idx_q  <= '0;
      resp_pend_q <= 1'b0;
      resp_idx_q  <= '0;
      prot_err_q  <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      lock_vld_q  <= lock_vld_d;
      lock_idx_q  <= lock_idx_d;
      resp_pend_q <= resp_pend_d;
      resp_idx_q  <= resp_idx_d;
      prot_err_q  <= prot_err_d;
    end
  end

  assign prot_err_o = prot_err_q;

endmodule

// File: tb/tb_event_unit_barrier_arbiter.sv
// Directed bench for event_unit_barrier_arbiter with a behavioural reference
// model and a barrier-unit model that grants on gnt_en and answers resp_delay
// cycles after each grant with rdata 0xA0 + core index.
module tb_event_unit_barrier_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    core_req_i;
  logic [N*AW-1:0] core_add_i;
  logic [N-1:0]    core_wen_i;
  logic [N*32-1:0] core_wdata_i;
  logic [N-1:0]    core_gnt_o;
  logic [N-1:0]    core_r_valid_o;
  logic [31:0]     core_r_rdata_o;
  logic            barr_req_o;
  logic [AW-1:0]   barr_add_o;
  logic            barr_wen_o;
  logic [31:0]     barr_wdata_o;
  logic            barr_gnt_i;
  logic            barr_r_valid_i;
  logic [31:0]     barr_r_rdata_i;
  logic            prot_err_o;

  event_unit_barrier_arbiter #(.NB_CORES(N), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .core_req_i(core_req_i), .core_add_i(core_add_i), .core_wen_i(core_wen_i),
    .core_wdata_i(core_wdata_i), .core_gnt_o(core_gnt_o),
    .core_r_valid_o(core_r_valid_o), .core_r_rdata_o(core_r_rdata_o),
    .barr_req_o(barr_req_o), .barr_add_o(barr_add_o), .barr_wen_o(barr_wen_o),
    .barr_wdata_o(barr_wdata_o), .barr_gnt_i(barr_gnt_i),
    .barr_r_valid_i(barr_r_valid_i), .barr_r_rdata_i(barr_r_rdata_i),
    .prot_err_o(prot_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] a_tab [N];
  logic [31:0] w_tab [N];
  logic        e_tab [N];

  // barrier environment controls
  int resp_delay = 1;
  bit gnt_en     = 1'b1;
  bit inject     = 1'b0;
  bit b_active   = 1'b0;
  int b_due      = 0;
  logic [31:0] b_rdata = '0;
  int cyc        = 0;
  bit cmp_en     = 1'b0;

  // reference model state
  int m_rr = 0;
  bit m_lock = 1'b0;
  int m_lock_idx = 0;
  bit m_pend = 1'b0;
  int m_pend_idx = 0;
  bit m_err = 1'b0;

  // per-cycle model outputs
  int          e_sel;
  bit          e_drop, e_req, e_hs, rv_due;
  logic [31:0] e_add, e_wdata, e_rdata;
  logic        e_wen;
  logic [N-1:0] e_gnt, e_rv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Barrier model drive, reference model compare, then model update
  always @(negedge clk) begin
    #1;
    rv_due         = b_active && (b_due == cyc);
    barr_gnt_i     = gnt_en;
    barr_r_valid_i = inject || rv_due;
    barr_r_rdata_i = inject ? 32'hDEAD0000 : (rv_due ? b_rdata : 32'h0);
    #1;
    // a locked core is kept; otherwise rotate from m_rr to the first requester
    e_drop = m_lock && !core_req_i[m_lock_idx];
    e_sel  = 0;
    if (m_lock) e_sel = m_lock_idx;
    else begin
      for (int k = N-1; k >= 0; k--)
        if (core_req_i[(m_rr + k) % N]) e_sel = (m_rr + k) % N;
    end
    e_req   = (core_req_i != 0) && (!m_pend || barr_r_valid_i) && !e_drop;
    e_hs    = e_req && barr_gnt_i;
    e_add   = e_req ? a_tab[e_sel] : 32'h0;
    e_wdata = e_req ? w_tab[e_sel] : 32'h0;
    e_wen   = e_req ? e_tab[e_sel] : 1'b0;
    e_gnt   = e_hs ? N'(1 << e_sel) : '0;
    e_rv    = (m_pend && barr_r_valid_i) ? N'(1 << m_pend_idx) : '0;
    e_rdata = (m_pend && barr_r_valid_i) ? barr_r_rdata_i : 32'h0;
    if (cmp_en) begin
      check("barr_req", 64'(barr_req_o), 64'(e_req));
      check("barr_add", 64'(barr_add_o), 64'(e_add));
      check("barr_wen_wdata", 64'({barr_wen_o, barr_wdata_o}), 64'({e_wen, e_wdata}));
      check("core_gnt", 64'(core_gnt_o), 64'(e_gnt));
      check("core_resp", 64'({core_r_valid_o, core_r_rdata_o}), 64'({e_rv, e_rdata}));
      check("prot_err", 64'(prot_err_o), 64'(m_err));
    end
    if (rst) begin
      m_rr = 0; m_lock = 0; m_lock_idx = 0; m_pend = 0; m_pend_idx = 0; m_err = 0;
      b_active = 0;
      cmp_en   = 1'b1;
    end else begin
      if (barr_r_valid_i) begin
        if (m_pend) m_pend = 0;
        else m_err = 1;
      end
      if (e_hs) begin
`ifdef EVENT_UNIT_BARR_ARB_RR_EN
        m_rr = (e_sel + 1) % N;
`else
        m_rr = 0;
`endif
        m_lock = 0; m_pend = 1; m_pend_idx = e_sel;
      end else if (e_req) begin
        m_lock = 1; m_lock_idx = e_sel;
      end else if (e_drop) begin
        m_lock = 0; m_err = 1;
      end
      if (rv_due) b_active = 0;
      if (barr_req_o && barr_gnt_i) begin
        b_active = 1;
        b_due    = cyc + resp_delay;
        b_rdata  = 32'hA0 + (barr_add_o - 32'h1000) / 4;
      end
    end
    cyc++;
  end

  task automatic drive(input logic [N-1:0] r, input logic rs);
    @(negedge clk);
    core_req_i = r;
    rst        = rs;
  endtask

  logic [N-1:0] r, g;

  initial begin
    rst = 1'b1; core_req_i = '0;
    barr_gnt_i = 1'b0; barr_r_valid_i = 1'b0; barr_r_rdata_i = '0;
    for (int i = 0; i < N; i++) begin
      a_tab[i] = 32'h1000 + 32'(i) * 4;
      w_tab[i] = 32'h5000 + 32'(i);
      e_tab[i] = (i % 2) == 1;
      core_add_i[i*AW +: AW]  = a_tab[i];
      core_wdata_i[i*32 +: 32] = w_tab[i];
      core_wen_i[i]            = e_tab[i];
    end
    drive('0, 1'b1);
    drive('0, 1'b1);

    // idle after reset
    for (int c = 0; c < 5; c++) begin
      drive(4'b0000, 1'b0); #3;
      check("idle_req", 64'(barr_req_o), 64'(0));
      check("idle_core", 64'({core_gnt_o, core_r_valid_o, core_r_rdata_o}), 64'(0));
      check("idle_err", 64'(prot_err_o), 64'(0));
    end

    // all cores request, each withdraws after its grant
    g = '0; r = 4'b1111;
`ifdef EVENT_UNIT_BARR_ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      r = r & ~g;
      drive(r, 1'b0); #3;
      check("rr_gnt", 64'(core_gnt_o), 64'(1 << k));
      if (k > 0) check("rr_resp", 64'({core_r_valid_o, core_r_rdata_o}),
                       64'({4'(1 << (k-1)), 32'hA0 + 32'(k-1)}));
      g = core_gnt_o;
    end
    drive(4'b0000, 1'b0); #3;
    check("rr_resp_last", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b1000, 32'hA3}));
`else
    for (int k = 0; k < N; k++) begin
      r = (r & ~g) | 4'b0001;
      drive(r, 1'b0); #3;
      check("fp_gnt", 64'(core_gnt_o), 64'(4'b0001));
      if (k > 0) check("fp_resp", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b0001, 32'hA0}));
      g = core_gnt_o;
    end
    r = 4'b1110;
    for (int k = 1; k < N; k++) begin
      drive(r, 1'b0); #3;
      check("fp_drain_gnt", 64'(core_gnt_o), 64'(1 << k));
      r = r & ~core_gnt_o;
    end
`endif
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);

    // lock holds core2 while core0 joins and the barrier stalls
    gnt_en = 1'b0;
    drive(4'b0100, 1'b0); #3;
    check("lock_req", 64'({barr_req_o, core_gnt_o}), 64'({1'b1, 4'b0000}));
    check("lock_add0", 64'(barr_add_o), 64'(32'h1008));
    drive(4'b0101, 1'b0); #3;
    check("lock_add1", 64'(barr_add_o), 64'(32'h1008));
    drive(4'b0101, 1'b0); #3;
    check("lock_add2", 64'(barr_add_o), 64'(32'h1008));
    gnt_en = 1'b1;
    drive(4'b0101, 1'b0); #3;
    check("lock_gnt", 64'(core_gnt_o), 64'(4'b0100));
    drive(4'b0001, 1'b0); #3;
    check("lock_next_gnt", 64'(core_gnt_o), 64'(4'b0001));
    check("lock_resp", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b0100, 32'hA2}));
    drive(4'b0000, 1'b0); #3;
    check("lock_resp0", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b0001, 32'hA0}));
    drive(4'b0000, 1'b0);

    // slow barrier: issue blocked until the response cycle
    resp_delay = 3;
    drive(4'b0010, 1'b0); #3;
    check("slow_gnt", 64'(core_gnt_o), 64'(4'b0010));
    drive(4'b1000, 1'b0); #3;
    check("slow_block1", 64'(barr_req_o), 64'(0));
    drive(4'b1000, 1'b0); #3;
    check("slow_block2", 64'(barr_req_o), 64'(0));
    drive(4'b1000, 1'b0); #3;
    check("slow_b2b_gnt", 64'(core_gnt_o), 64'(4'b1000));
    check("slow_resp", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b0010, 32'hA1}));
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0); #3;
    check("slow_resp3", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b1000, 32'hA3}));
    drive(4'b0000, 1'b0);

    // spurious response sets the sticky error
    drive(4'b0000, 1'b0); inject = 1'b1; #3;
    check("spur_resp", 64'({core_r_valid_o, core_r_rdata_o}), 64'(0));
    for (int c = 0; c < 3; c++) begin
      drive(4'b0000, 1'b0); inject = 1'b0; #3;
      check("spur_err_sticky", 64'(prot_err_o), 64'(1));
    end

    // reset while a response is pending
    drive(4'b0001, 1'b0); #3;
    check("rst_pre_gnt", 64'(core_gnt_o), 64'(4'b0001));
    drive(4'b0000, 1'b1); #3;
    check("rst_cycle_err", 64'(prot_err_o), 64'(1));
    resp_delay = 1;
    drive(4'b0000, 1'b0); #3;
    check("rst_err_clr", 64'(prot_err_o), 64'(0));
    drive(4'b0010, 1'b0); #3;
    check("rst_pend_dropped", 64'(core_gnt_o), 64'(4'b0010));
    drive(4'b0000, 1'b0); #3;
    check("rst_new_resp", 64'({core_r_valid_o, core_r_rdata_o}), 64'({4'b0010, 32'hA1}));

    // locked core withdrawing is a protocol error and frees the lock
    gnt_en = 1'b0;
    drive(4'b0100, 1'b0);
    drive(4'b0000, 1'b0); #3;
    check("drop_req", 64'(barr_req_o), 64'(0));
    gnt_en = 1'b1;
    drive(4'b0001, 1'b0); #3;
    check("drop_err", 64'(prot_err_o), 64'(1));
    check("drop_fresh_gnt", 64'(core_gnt_o), 64'(4'b0001));
    drive(4'b0000, 1'b0);
    drive(4'b0000, 1'b0);
    @(negedge clk); #3;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
